// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for multi_clock_divider.
// Config FSM states and counter width sizing.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    APPLY,
    ERR
  } cfg_state_t;

  function automatic int cnt_width(input int base);
    return $clog2(base) + 1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, WIDTH cycles.
// done pulses for one cycle exactly when quotient becomes valid.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   w_shift;
  logic             w_fits;

  // Partial remainder shifted left with the next dividend bit
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, r_div});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem  <= '0;
        r_q    <= dividend;
        r_div  <= divisor;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (w_fits) begin
          r_rem <= WIDTH'(w_shift - {1'b0, r_div});
          r_q   <= {r_q[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b0};
        end
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_q;

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel reprogrammable clock/tick generator with a shared divider.
// Define PHASE_ALIGN_EN to add the align input that zeroes all counters.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int BASE_SPEED    = 50000000,
  parameter int NUM_CH        = 4,
  parameter int SPEED_W       = $clog2(1000000) + 1,
  parameter int CNT_W         = cnt_width(BASE_SPEED),
  parameter int DEFAULT_SPEED = 1,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset_button,
  input  logic [NUM_CH-1:0]  enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_chan,
  input  logic [SPEED_W-1:0] cfg_speed,
  output logic               cfg_err,
`ifdef PHASE_ALIGN_EN
  input  logic               align,
`endif
  output logic [NUM_CH-1:0]  outClk,
  output logic [NUM_CH-1:0]  tick
);

  localparam logic [CNT_W-1:0] MAX_RST  =
    CNT_W'(BASE_SPEED / DEFAULT_SPEED - 1);
  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(BASE_SPEED);
  localparam int               DCW      = $clog2(CNT_W + 1);
  localparam logic [DCW-1:0]   DIV_LAST = DCW'(CNT_W - 1);

  cfg_state_t        r_state;
  logic [CH_W-1:0]   r_chan;
  logic [DCW-1:0]    r_div_cnt;
  logic              r_cfg_ready;
  logic              r_cfg_err;

  logic [CNT_W-1:0]  r_cnt      [NUM_CH];
  logic [CNT_W-1:0]  r_max      [NUM_CH];
  logic [CNT_W-1:0]  r_pend_max [NUM_CH];
  logic [CNT_W:0]    w_half     [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_out_clk;
  logic [NUM_CH-1:0] r_tick;

  logic              w_accept;
  logic              w_bad;
  logic              w_start;
  logic              w_apply;
  logic              w_align;
  logic              w_div_busy;
  logic              w_div_done;
  logic [CNT_W-1:0]  w_q;

`ifdef PHASE_ALIGN_EN
  assign w_align = align;
`else
  assign w_align = 1'b0;
`endif

  assign w_accept = cfg_valid && r_cfg_ready && !w_div_busy;
  assign w_bad    = (cfg_speed == '0) ||
                    (32'(cfg_speed) > 32'(BASE_SPEED / 2)) ||
                    (32'(cfg_chan) >= 32'(NUM_CH));
  assign w_start  = w_accept && !w_bad;
  assign w_apply  = (r_state == APPLY) && w_div_done;

  seq_divider #(
    .WIDTH (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst      (reset_button),
    .start    (w_start),
    .dividend (DIVIDEND),
    .divisor  (CNT_W'(cfg_speed)),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_q)
  );

  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      r_state     <= IDLE;
      r_chan      <= '0;
      r_div_cnt   <= '0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_chan      <= cfg_chan;
            r_cfg_ready <= 1'b0;
            if (w_bad) begin
              r_state   <= ERR;
              r_cfg_err <= 1'b1;
            end else begin
              r_state   <= DIV;
              r_div_cnt <= '0;
            end
          end
        end
        DIV: begin
          r_div_cnt <= r_div_cnt + DCW'(1);
          if (r_div_cnt == DIV_LAST) r_state <= APPLY;
        end
        APPLY: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
        end
        ERR: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_half[i] = ({1'b0, r_max[i]} + (CNT_W+1)'(1)) >> 1;
    end
  end

  // Pending max is only adopted at a wrap so no period is truncated
  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]      <= '0;
        r_max[i]      <= MAX_RST;
        r_pend_max[i] <= '0;
      end
      r_pend    <= '0;
      r_out_clk <= '0;
      r_tick    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!enable[i] || w_align) begin
          r_cnt[i]     <= '0;
          r_out_clk[i] <= 1'b0;
          r_tick[i]    <= 1'b0;
          if (r_pend[i]) begin
            r_max[i]  <= r_pend_max[i];
            r_pend[i] <= 1'b0;
          end
        end else begin
          r_out_clk[i] <= ({1'b0, r_cnt[i]} >= w_half[i]);
          r_tick[i]    <= (r_cnt[i] == r_max[i]);
          if (r_cnt[i] == r_max[i]) begin
            r_cnt[i] <= '0;
            if (r_pend[i]) begin
              r_max[i]  <= r_pend_max[i];
              r_pend[i] <= 1'b0;
            end
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
        if (w_apply && (r_chan == CH_W'(i))) begin
          r_pend_max[i] <= w_q - CNT_W'(1);
          r_pend[i]     <= 1'b1;
        end
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign outClk    = r_out_clk;
  assign tick      = r_tick;

endmodule
